// File: rtl/hgcal_input_packer.sv
// Packs a beat stream of quantized features into one wide frame for the layer-0 LUT array.
// Frames of the wrong length are flagged with a one-cycle error pulse and never presented.
module hgcal_input_packer #(
    parameter int FEAT_BITS      = 2,
    parameter int NUM_FEATS      = 48,
    parameter int FEATS_PER_BEAT = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic [FEATS_PER_BEAT*FEAT_BITS-1:0] s_data,
    input  logic                                s_last,
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic [NUM_FEATS*FEAT_BITS-1:0]      m_data,
    output logic                                err_short,
    output logic                                err_long,
    output logic [1:0]                          o_dbg_state
);

    localparam int BEATS   = NUM_FEATS / FEATS_PER_BEAT;
    localparam int BEAT_W  = FEATS_PER_BEAT * FEAT_BITS;
    localparam int FRAME_W = NUM_FEATS * FEAT_BITS;
    localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    // Handshake: a beat moves when s_valid && s_ready, a frame moves when
    // m_valid && m_ready; s_ready and m_valid are pure functions of the state.

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [FRAME_W-1:0]   r_data;
    logic                 r_err_short;
    logic                 r_err_long;

    state_t               w_state_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 w_err_short_nxt;
    logic                 w_err_long_nxt;
    logic                 w_wr_en;
    logic                 w_beat;
    logic                 w_last_slot;

    assign w_beat      = s_valid && s_ready;
    assign w_last_slot = (r_cnt == LAST_CNT);

    // State register plus the datapath registers it governs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_FILL;
            r_cnt       <= '0;
            r_data      <= '0;
            r_err_short <= 1'b0;
            r_err_long  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_err_short <= w_err_short_nxt;
            r_err_long  <= w_err_long_nxt;
            if (w_wr_en) begin
                r_data[r_cnt*BEAT_W +: BEAT_W] <= s_data;
            end
        end
    end

    // Next-state and counter logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_err_short_nxt = 1'b0;
        w_err_long_nxt  = 1'b0;
        w_wr_en         = 1'b0;
        unique case (r_state)
            ST_FILL: begin
                if (w_beat) begin
                    w_wr_en = 1'b1;
                    if (w_last_slot) begin
                        w_cnt_nxt = '0;
                        if (s_last) begin
                            w_state_nxt = ST_HOLD;
                        end else begin
                            w_state_nxt    = ST_DISCARD;
                            w_err_long_nxt = 1'b1;
                        end
                    end else if (s_last) begin
                        // Short frame: restart; the stale partial bits get overwritten later.
                        w_cnt_nxt       = '0;
                        w_err_short_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (m_ready) begin
                    w_state_nxt = ST_FILL;
                end
            end
            ST_DISCARD: begin
                if (w_beat && s_last) begin
                    w_state_nxt = ST_FILL;
                end
            end
            default: begin
                w_state_nxt = ST_FILL;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs decoded from the registered state only.
    always_comb begin
        s_ready     = (r_state != ST_HOLD);
        m_valid     = (r_state == ST_HOLD);
        m_data      = r_data;
        err_short   = r_err_short;
        err_long    = r_err_long;
        o_dbg_state = r_state;
    end

endmodule
